// File: rtl/fft_stream_core.sv
// fft_stream_core
//   Iterative radix-2 decimation-in-time FFT with streaming ports.
//   N = 2**LOG2N real samples are loaded in bit-reversed order. The transform
//   runs in place with one butterfly per cycle. The N complex bins are then
//   streamed out in natural order.
//
// Ports
//   clk, reset          clock; synchronous active-low reset (aborts any frame)
//   in_valid/in_ready   sample input handshake (in_ready high only while loading)
//   in_data             signed real sample, IN_W bits
//   scale               sampled on the final input handshake; 1 = halve after each stage
//   out_valid/out_ready bin output handshake (out_valid high only while unloading)
//   out_re/out_im       bin value, DATA_W bits signed, held while out_ready=0
//   out_index           bin number, out_last marks bin N-1
//   busy                high while computing or unloading
//   ovf                 sticky saturation flag for the current frame
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid & ready are both high. The source holds its data stable while valid
// is high and ready is low.
module fft_stream_core #(
  parameter int LOG2N  = 4,
  parameter int IN_W   = 18,
  parameter int DATA_W = 24,
  parameter int TW_W   = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              scale,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  localparam int N      = 1 << LOG2N;
  localparam int HALF_N = N / 2;
  localparam int KW     = LOG2N - 1;           // butterfly / twiddle index width
  localparam int SW     = $clog2(LOG2N);       // stage counter width
  localparam int EW     = DATA_W + 2;          // butterfly sum width
  localparam int PW     = DATA_W + TW_W + 1;   // complex product width

  localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
  localparam logic [KW-1:0]    LAST_BFLY  = KW'(HALF_N - 1);
  localparam logic [KW-1:0]    QUARTER_K  = KW'(N / 4);
  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);

  localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

  state_t state_q, state_d;

  logic [LOG2N-1:0] load_cnt;
  logic [LOG2N-1:0] out_idx_q;
  logic [SW-1:0]    stage_q;
  logic [KW-1:0]    bfly_q;
  logic             scale_q;
  logic             ovf_q;

  logic signed [DATA_W-1:0] mem_re [N];
  logic signed [DATA_W-1:0] mem_im [N];

  // Twiddle W_k = exp(-j*2*pi*k/N), rounded half away from zero, built at elaboration.
  function automatic logic signed [TW_W-1:0] tw_val(input int k, input logic want_im);
    real ang, v, m;
    m   = 2.0 ** (TW_W - 1) - 1.0;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    v   = want_im ? -$sin(ang) * m : $cos(ang) * m;
    if (v >= 0.0) return TW_W'($rtoi(v + 0.5));
    else          return TW_W'($rtoi(v - 0.5));
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Returns {saturated, clipped value}.
  function automatic logic [DATA_W:0] sat_f(input logic signed [EW-1:0] v);
    if (v > EW'(MAX_D))      return {1'b1, MAX_D};
    else if (v < EW'(MIN_D)) return {1'b1, MIN_D};
    else                     return {1'b0, v[DATA_W-1:0]};
  endfunction

  logic signed [TW_W-1:0] tw_re_rom [HALF_N];
  logic signed [TW_W-1:0] tw_im_rom [HALF_N];

  for (genvar g = 0; g < HALF_N; g++) begin : g_twiddle
    localparam logic signed [TW_W-1:0] TW_RE = tw_val(g, 1'b0);
    localparam logic signed [TW_W-1:0] TW_IM = tw_val(g, 1'b1);
    assign tw_re_rom[g] = TW_RE;
    assign tw_im_rom[g] = TW_IM;
  end

  // Handshakes
  logic load_fire, out_fire, compute_last;
  assign load_fire    = (state_q == ST_LOAD) && in_valid;
  assign out_fire     = (state_q == ST_UNLOAD) && out_ready;
  assign compute_last = (state_q == ST_COMPUTE) && (stage_q == LAST_STAGE) && (bfly_q == LAST_BFLY);

  // Butterfly addressing: top = (b>>s)*2*half + pos is the same as inserting
  // a zero at bit s of b; bot sets that bit.
  logic [LOG2N-1:0] b_ext, half, pos_mask, top_idx, bot_idx;
  logic [KW-1:0]    tw_k;

  always_comb begin
    b_ext    = {1'b0, bfly_q};
    half     = LOG2N'(1) << stage_q;
    pos_mask = half - LOG2N'(1);
    top_idx  = ((b_ext & ~pos_mask) << 1) | (b_ext & pos_mask);
    bot_idx  = top_idx | half;
    tw_k     = KW'((b_ext & pos_mask) << (LAST_STAGE - stage_q));
  end

  // Butterfly datapath
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [PW-1:0]     prod_re, prod_im;
  logic signed [EW-1:0]     p_re, p_im;
  logic signed [EW-1:0]     sum_t_re, sum_t_im, sum_b_re, sum_b_im;
  logic signed [EW-1:0]     scl_t_re, scl_t_im, scl_b_re, scl_b_im;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;
  logic                     sat_t_re, sat_t_im, sat_b_re, sat_b_im;

  assign a_re = mem_re[top_idx];
  assign a_im = mem_im[top_idx];
  assign b_re = mem_re[bot_idx];
  assign b_im = mem_im[bot_idx];
  assign w_re = tw_re_rom[tw_k];
  assign w_im = tw_im_rom[tw_k];

  always_comb begin
    prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    // k=0 and k=N/4 are exact rotations; the rounded twiddles would lose a bit.
    if (tw_k == '0) begin
      p_re = EW'(b_re);
      p_im = EW'(b_im);
    end else if (tw_k == QUARTER_K) begin
      p_re = EW'(b_im);
      p_im = -EW'(b_re);
    end else begin
      p_re = EW'(prod_re >>> (TW_W - 1));
      p_im = EW'(prod_im >>> (TW_W - 1));
    end
    sum_t_re = EW'(a_re) + p_re;
    sum_t_im = EW'(a_im) + p_im;
    sum_b_re = EW'(a_re) - p_re;
    sum_b_im = EW'(a_im) - p_im;
  end

  assign scl_t_re = scale_q ? (sum_t_re >>> 1) : sum_t_re;
  assign scl_t_im = scale_q ? (sum_t_im >>> 1) : sum_t_im;
  assign scl_b_re = scale_q ? (sum_b_re >>> 1) : sum_b_re;
  assign scl_b_im = scale_q ? (sum_b_im >>> 1) : sum_b_im;

  assign {sat_t_re, top_re} = sat_f(scl_t_re);
  assign {sat_t_im, top_im} = sat_f(scl_t_im);
  assign {sat_b_re, bot_re} = sat_f(scl_b_re);
  assign {sat_b_im, bot_im} = sat_f(scl_b_im);

  // FSM
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:    if (load_fire && (load_cnt == LAST_IDX)) state_d = ST_COMPUTE;
      ST_COMPUTE: if (compute_last) state_d = ST_UNLOAD;
      ST_UNLOAD:  if (out_fire && (out_idx_q == LAST_IDX)) state_d = ST_LOAD;
      default:    state_d = ST_LOAD;
    endcase
  end

  // Counters and frame flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      load_cnt  <= '0;
      out_idx_q <= '0;
      stage_q   <= '0;
      bfly_q    <= '0;
      scale_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (load_fire) begin
        load_cnt <= load_cnt + LOG2N'(1);
        if (load_cnt == '0) ovf_q <= 1'b0;
        if (load_cnt == LAST_IDX) scale_q <= scale;
      end
      if (state_q == ST_COMPUTE) begin
        if (sat_t_re || sat_t_im || sat_b_re || sat_b_im) ovf_q <= 1'b1;
        if (bfly_q == LAST_BFLY) begin
          bfly_q  <= '0;
          stage_q <= (stage_q == LAST_STAGE) ? '0 : stage_q + SW'(1);
        end else begin
          bfly_q <= bfly_q + KW'(1);
        end
      end
      if (out_fire) out_idx_q <= out_idx_q + LOG2N'(1);
    end
  end

  // Sample memory (not reset); both butterfly results land on the same edge.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_re[bitrev(load_cnt)] <= DATA_W'($signed(in_data));
      mem_im[bitrev(load_cnt)] <= '0;
    end else if (state_q == ST_COMPUTE) begin
      mem_re[top_idx] <= top_re;
      mem_im[top_idx] <= top_im;
      mem_re[bot_idx] <= bot_re;
      mem_im[bot_idx] <= bot_im;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_UNLOAD);
  assign busy      = (state_q != ST_LOAD);
  assign out_index = out_idx_q;
  assign out_last  = out_valid && (out_idx_q == LAST_IDX);
  assign out_re    = out_valid ? mem_re[out_idx_q] : '0;
  assign out_im    = out_valid ? mem_im[out_idx_q] : '0;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_stream_core.sv
`timescale 1ns/1ps
module tb_fft_stream_core;

  localparam int LOG2N  = 4;
  localparam int N      = 16;
  localparam int IN_W   = 18;
  localparam int DATA_W = 24;
  localparam int TW_W   = 24;
  localparam int SAT_W  = 20;
  localparam int W      = 64;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            scale = 1'b0;
  logic            out_ready = 1'b0;
  logic [IN_W-1:0] in_data = '0;

  logic              in_ready, out_valid, out_last, busy, ovf;
  logic [DATA_W-1:0] out_re, out_im;
  logic [LOG2N-1:0]  out_index;

  logic              in_ready_s, out_valid_s, out_last_s, busy_s, ovf_s;
  logic [SAT_W-1:0]  out_re_s, out_im_s;
  logic [LOG2N-1:0]  out_index_s;

  fft_stream_core #(.LOG2N(LOG2N), .IN_W(IN_W), .DATA_W(DATA_W), .TW_W(TW_W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .scale(scale), .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
    .out_im(out_im), .out_index(out_index), .out_last(out_last), .busy(busy), .ovf(ovf)
  );

  // Narrow instance for saturation; it sees the same stimulus and runs in lockstep.
  fft_stream_core #(.LOG2N(LOG2N), .IN_W(IN_W), .DATA_W(SAT_W), .TW_W(TW_W)) u_dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .scale(scale), .out_valid(out_valid_s), .out_ready(out_ready), .out_re(out_re_s),
    .out_im(out_im_s), .out_index(out_index_s), .out_last(out_last_s), .busy(busy_s), .ovf(ovf_s)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_re_q[$];
  logic [W-1:0] exp_im_q[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: textbook in-place DIT FFT over integer arrays.
  function automatic void fft_model(input longint x[N], input bit sc, input int dw,
                                    output longint yr[N], output longint yi[N], output bit of);
    longint lim_hi, lim_lo, ar, ai, br, bi, wr, wi, pr, pi, v[4];
    real    m, ang, c, s;
    int     rev, half, top, bot, k;
    lim_hi = (longint'(1) <<< (dw - 1)) - 1;
    lim_lo = -(longint'(1) <<< (dw - 1));
    m = 2.0 ** (TW_W - 1) - 1.0;
    of = 1'b0;
    for (int n = 0; n < N; n++) begin
      rev = 0;
      for (int t = 0; t < LOG2N; t++) if (n & (1 << t)) rev += N >> (t + 1);
      yr[rev] = x[n];
      yi[rev] = 0;
    end
    for (int st = 0; st < LOG2N; st++) begin
      half = 2 ** st;
      for (int b = 0; b < N / 2; b++) begin
        top = (b / half) * 2 * half + (b % half);
        bot = top + half;
        k   = (b % half) * (N / (2 * half));
        ar = yr[top]; ai = yi[top]; br = yr[bot]; bi = yi[bot];
        if (k == 0) begin
          pr = br; pi = bi;
        end else if (k == N / 4) begin
          pr = bi; pi = -br;
        end else begin
          ang = 2.0 * 3.14159265358979323846 * k / N;
          c = $cos(ang) * m;
          s = -$sin(ang) * m;
          wr = (c < 0.0) ? -longint'($rtoi($floor(-c + 0.5))) : longint'($rtoi($floor(c + 0.5)));
          wi = (s < 0.0) ? -longint'($rtoi($floor(-s + 0.5))) : longint'($rtoi($floor(s + 0.5)));
          pr = (br * wr - bi * wi) >>> (TW_W - 1);
          pi = (br * wi + bi * wr) >>> (TW_W - 1);
        end
        v[0] = ar + pr; v[1] = ai + pi; v[2] = ar - pr; v[3] = ai - pi;
        for (int j = 0; j < 4; j++) begin
          if (sc) v[j] = v[j] >>> 1;
          if (v[j] > lim_hi) begin v[j] = lim_hi; of = 1'b1; end
          if (v[j] < lim_lo) begin v[j] = lim_lo; of = 1'b1; end
        end
        yr[top] = v[0]; yi[top] = v[1]; yr[bot] = v[2]; yi[bot] = v[3];
      end
    end
  endfunction

  // Driver: send one frame; tasks begin just after a rising edge.
  task automatic send_frame(input longint x[N], input bit sc, input bit rand_idle);
    for (int i = 0; i < N; i++) begin
      bit done = 1'b0;
      int guard = 0;
      if (rand_idle && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk); in_valid = 1'b0; @(posedge clk);
      end
      while (!done && guard < 100) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x[i][IN_W-1:0];
        scale    = sc;
        done     = in_ready;
        guard++;
        @(posedge clk);
      end
      if (!done) check("in_handshake_timeout", 0, 1);
      if (i == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        check("ovf_clear_first_hs", ovf, 0);
        check("ovf_clear_first_hs_sat", ovf_s, 0);
        @(posedge clk);
      end
    end
  endtask

  // Counts cycles after the last input handshake edge until out_valid rises.
  task automatic measure_latency();
    int cyc = 1;
    bit seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) seen = 1'b1;
      else begin @(posedge clk); cyc++; end
    end
    check("first_out_valid_cycle", cyc, LOG2N * N / 2 + 1);
  endtask

  task automatic collect_frame(input bit sel, input int hold_at, input bit rand_bp, input bit exp_ovf);
    int idx = 0;
    int guard = 0;
    int held = 0;
    while (idx < N && guard < 400) begin
      @(negedge clk);
      guard++;
      check("out_valid", sel ? out_valid_s : out_valid, 1);
      check("out_index", sel ? out_index_s : out_index, idx);
      check("out_re", sel ? longint'($signed(out_re_s)) : longint'($signed(out_re)), longint'($signed(exp_re_q[0])));
      check("out_im", sel ? longint'($signed(out_im_s)) : longint'($signed(out_im)), longint'($signed(exp_im_q[0])));
      check("out_last", sel ? out_last_s : out_last, (idx == N - 1) ? 1 : 0);
      check("ovf_unload", sel ? ovf_s : ovf, exp_ovf);
      if (idx == hold_at && held < 5) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      @(posedge clk);
      if (out_ready) begin
        idx++;
        void'(exp_re_q.pop_front());
        void'(exp_im_q.pop_front());
      end
    end
    if (idx < N) check("collect_timeout", idx, N);
    @(negedge clk);
    out_ready = 1'b0;
    check("back_in_ready", sel ? in_ready_s : in_ready, 1);
    check("back_busy", sel ? busy_s : busy, 0);
    check("back_out_valid", sel ? out_valid_s : out_valid, 0);
    @(posedge clk);
  endtask

  task automatic run_frame(input longint x[N], input bit sc, input longint er[N], input longint ei[N],
                           input bit eovf, input bit sel, input int hold_at, input bit rnd);
    exp_re_q.delete();
    exp_im_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_re_q.push_back(W'(er[i]));
      exp_im_q.push_back(W'(ei[i]));
    end
    send_frame(x, sc, rnd);
    measure_latency();
    collect_frame(sel, hold_at, rnd, eovf);
  endtask

  initial begin
    longint x[N], er[N], ei[N];
    bit     mo, sc, sel;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b1;
    @(posedge clk);

    // DC with 5-cycle stall at bin 3
    for (int i = 0; i < N; i++) begin x[i] = 1000; er[i] = 0; ei[i] = 0; end
    er[0] = 16000;
    run_frame(x, 1'b0, er, ei, 1'b0, 1'b0, 3, 1'b0);

    // Impulse
    for (int i = 0; i < N; i++) begin x[i] = 0; er[i] = 5000; ei[i] = 0; end
    x[0] = 5000;
    run_frame(x, 1'b0, er, ei, 1'b0, 1'b0, -1, 1'b1);

    // Alternating sign
    for (int i = 0; i < N; i++) begin x[i] = (i % 2) ? -4096 : 4096; er[i] = 0; ei[i] = 0; end
    er[8] = 65536;
    run_frame(x, 1'b0, er, ei, 1'b0, 1'b0, -1, 1'b0);

    // Per-frame scale latching
    for (int i = 0; i < N; i++) begin x[i] = 1000; er[i] = 0; ei[i] = 0; end
    er[0] = 1000;
    run_frame(x, 1'b1, er, ei, 1'b0, 1'b0, -1, 1'b0);
    er[0] = 16000;
    run_frame(x, 1'b0, er, ei, 1'b0, 1'b0, -1, 1'b0);

    // Saturation on the narrow instance, then ovf clears on the next frame
    for (int i = 0; i < N; i++) begin x[i] = 131071; er[i] = 0; ei[i] = 0; end
    er[0] = 524287;
    run_frame(x, 1'b0, er, ei, 1'b1, 1'b1, -1, 1'b0);
    for (int i = 0; i < N; i++) begin x[i] = 1000; er[i] = 0; ei[i] = 0; end
    er[0] = 16000;
    run_frame(x, 1'b0, er, ei, 1'b0, 1'b1, -1, 1'b0);

    // Randomized frames against the model, both instances
    for (int f = 0; f < 6; f++) begin
      sel = f[0];
      sc  = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) x[i] = longint'($urandom_range(0, 262142)) - 131071;
      fft_model(x, sc, sel ? SAT_W : DATA_W, er, ei, mo);
      run_frame(x, sc, er, ei, mo, sel, -1, 1'b1);
    end

    // Abort mid-compute
    for (int i = 0; i < N; i++) x[i] = 1000;
    send_frame(x, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_index", out_index, 0);
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin x[i] = 1000; er[i] = 0; ei[i] = 0; end
    er[0] = 16000;
    run_frame(x, 1'b0, er, ei, 1'b0, 1'b0, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_stream_core.md
Name: fft_stream_core

Overview:
Parametrised iterative radix-2 DIT FFT core with streaming interfaces. It accepts N=2^LOG2N real samples over a valid/ready input and computes the transform in place using one time-multiplexed butterfly. It then streams N complex bins out in natural order over a valid/ready output. It adds runtime per-stage scaling, saturation and an overflow flag.

Parameters:
LOG2N, 4, log2 of transform size N (valid range 2..10)
IN_W, 18, input sample width, signed
DATA_W, 24, internal and output real/imag width, signed, with DATA_W >= IN_W
TW_W, 24, twiddle width, signed Q1.(TW_W-1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  high only in LOAD
in_data  in  IN_W  signed real sample
scale  in  1  sampled on the final input handshake; 1 = divide by 2 after every stage
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts bin
out_re  out  DATA_W  bin real part
out_im  out  DATA_W  bin imaginary part
out_index  out  LOG2N  bin number
out_last  out  1  high with bin N-1
busy  out  1  high in COMPUTE or UNLOAD
ovf  out  1  sticky saturation flag for the current frame

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_re/out_im/out_index=0, out_last=0, busy=0, ovf=0, all counters 0, state LOAD. Data memory is not cleared.
- Reset asserted in any state aborts the frame. No partial output is produced.
- States: LOAD -> COMPUTE -> UNLOAD -> LOAD. There is no frame overlap.
- LOAD:
  - Handshake occurs when in_valid & in_ready.
  - Sample n is written to mem[bitrev(n)] with re = sign-extended in_data and im = 0.
  - The first handshake of a frame clears ovf.
  - The Nth handshake latches scale and enters COMPUTE.
- COMPUTE: exactly LOG2N·N/2 cycles, one butterfly per cycle.
  - Stage s = 0..LOG2N-1, butterfly b = 0..N/2-1.
  - half = 2^s; pos = b mod half; top = (b>>s)·2·half + pos; bot = top+half; k = pos<<(LOG2N-1-s).
  - Twiddle: W_k = e^(-j2πk/N), from a ROM built at elaboration. re = round(cos·(2^(TW_W-1)-1)), im = -round(sin·(2^(TW_W-1)-1)).
  - Multiplier bypass: k=0 uses P=B exactly. k=N/4 uses P=(B.im, -B.re) exactly.
  - Otherwise P = complex W_k·B with full-precision products, then arithmetic shift right by TW_W-1 (floor).
  - Outputs: top' = A+P, bot' = A-P, computed at DATA_W+2 bits. Then arithmetic >>1 if scale is latched. Then saturate to the signed DATA_W range.
  - Any saturation sets ovf.
  - Both results are written back on the same edge.
- UNLOAD:
  - Bins are presented in natural order. out_re/out_im = mem[out_index].
  - out_valid stays high; values are held stable while out_ready=0.
  - out_index increments on each handshake.
  - out_last = out_valid & (out_index==N-1).
  - Handshake on bin N-1 returns to LOAD; in_ready=1 in the next cycle.
- Latency: first out_valid occurs in cycle LOG2N·N/2+1 after the last input handshake edge (cycle 33 for N=16).
- in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.
- ovf stays valid through UNLOAD.

Test Plan:
1. DC: N=16, 16 samples of 1000, scale=0 -> bin0 = (16000, 0), bins 1..15 = (0, 0), ovf=0; first out_valid 33 cycles after last input handshake.
2. Impulse: x0=5000, others 0 -> all 16 bins = (5000, 0) exactly.
3. Alternating x[n] = (-1)^n·4096 -> bin8 = (65536, 0), all other bins (0, 0).
4. Scaling: DC 1000 with scale=1 -> bin0 = (1000, 0), others 0. Repeat with scale=0 on the next frame -> bin0 = 16000, proving per-frame latching.
5. Saturation: instance with DATA_W=20, DC 131071 -> bin0 re = 524287, ovf=1 through UNLOAD. The next frame with DC 1000 clears ovf on its first handshake.
6. Backpressure and abort:
   - Hold out_ready=0 for 5 cycles at bin 3 -> out_index=3 and data stable throughout.
   - Assert reset mid-COMPUTE -> next cycle in_ready=1, busy=0, out_valid=0. A following DC frame gives the correct result.
